gemm_sequencer: RTL and testbench
=================================

Name: gemm_sequencer

Overview:
- Instruction-driven controller between inst_reader and systolic_array_top.
- Consumes decoded LD/ST/GEMM/DRAINSYS instructions through a valid/ready handshake.
- Drives the array's i_ctrl_state, the per-buffer SRAM read start/end addresses, and the down-buffer readback port.
- Replaces the hand-timed IDLE/STEADY/DRAIN sequencing with counted, parameterised phases.

Parameters:
- NUM_ROW, 4, systolic rows
- NUM_COL, 4, systolic columns
- LOG2_SRAM_BANK_DEPTH, 5, SRAM address width
- CTRL_WIDTH, 4, width of ctrl state bus
- OPCODE_WIDTH, 4, opcode field width
- BUF_ID_WIDTH, 2, buffer-id field width
- MEM_LOC_WIDTH, 10, memory-location field width
- STEADY_CYCLES, 10, cycles held in STEADY per GEMM
- DRAIN_CYCLES, 6, cycles held in DRAIN per DRAINSYS

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_inst_valid  in  1  instruction present
- o_inst_ready  out  1  sequencer accepts instruction this cycle
- i_opcode  in  OPCODE_WIDTH  0010 LD, 0011 ST, 0100 GEMM, 0101 DRAINSYS
- i_buf_id  in  BUF_ID_WIDTH  0 top, 1 left, 2 down, 3 reserved
- i_mem_loc  in  MEM_LOC_WIDTH  base location
- o_ctrl_state  out  CTRL_WIDTH  to array i_ctrl_state: 0 IDLE, 1 STEADY, 3 DRAIN
- o_top_rd_start_addr, o_top_rd_end_addr  out  LOG2_SRAM_BANK_DEPTH each  top SRAM window
- o_left_rd_start_addr, o_left_rd_end_addr  out  LOG2_SRAM_BANK_DEPTH each  left SRAM window
- o_down_rd_start_addr, o_down_rd_end_addr  out  LOG2_SRAM_BANK_DEPTH each  down SRAM window
- o_down_rd_en  out  1  down-buffer read strobe
- o_down_rd_addr  out  LOG2_SRAM_BANK_DEPTH  down-buffer read address
- o_busy  out  1  not in S_IDLE
- o_err  out  1  one-cycle pulse on illegal instruction

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is synchronous and active-high; it is sampled on posedge clk only. All outputs clear to 0 except o_inst_ready, which is 1 the cycle after rst deasserts. Reset mid-phase aborts immediately: state goes to S_IDLE, counters clear, address registers clear.
- States:
  - S_IDLE: o_ctrl_state=0, o_inst_ready=1.
  - S_STEADY: o_ctrl_state=1.
  - S_DRAIN: o_ctrl_state=3.
  - S_STORE: o_ctrl_state=0, o_down_rd_en=1.
  - o_inst_ready=0 in every state except S_IDLE.
- Accept: an instruction is accepted when i_inst_valid && o_inst_ready at posedge.
- LD:
  - Completes in the accept cycle; state stays S_IDLE.
  - start = i_mem_loc[LOG2_SRAM_BANK_DEPTH-1:0], taking the low bits.
  - end = start + NUM_ROW+NUM_COL-2, computed modulo 2^LOG2_SRAM_BANK_DEPTH (wrap allowed).
  - Written to the window selected by buf_id; the new values are visible the next cycle.
  - buf_id=3 -> no update, o_err pulse.
- GEMM:
  - Next cycle enters S_STEADY for exactly STEADY_CYCLES cycles, then S_IDLE.
  - buf_id and mem_loc are ignored.
- DRAINSYS: S_DRAIN for exactly DRAIN_CYCLES cycles, then S_IDLE.
- ST:
  - S_STORE for NUM_ROW cycles.
  - o_down_rd_addr = o_down_rd_start_addr + k for k = 0..NUM_ROW-1, wrapping.
  - Then S_IDLE with o_down_rd_en=0.
- Unknown opcode: dropped, o_err pulse the next cycle, state unchanged.
- Counter: a single phase counter, clog2(max(STEADY_CYCLES, DRAIN_CYCLES, NUM_ROW))+1 bits wide. It loads the phase length minus one on entry; exit occurs on the cycle after it reads 0.
- Back-to-back: o_inst_ready rises on the first S_IDLE cycle after a phase. There is no bubble beyond that, so GEMM then DRAINSYS gives STEADY immediately followed by one IDLE cycle, then DRAIN.
- Phase lengths of 0 are illegal; an elaboration-time check flags them.

Optional Feature:
- Macro: GEMM_AUTO_DRAIN_EN.
- Defined: after the STEADY phase of a GEMM completes, the sequencer passes directly into S_DRAIN for DRAIN_CYCLES cycles with no intervening IDLE cycle. An explicit DRAINSYS remains legal.
- Undefined: GEMM returns to S_IDLE after STEADY, and a drain requires DRAINSYS.

Decomposition:
- Shared package gemm_pkg holds:
  - opcode constants OPC_LD/OPC_ST/OPC_GEMM/OPC_DRAINSYS;
  - buffer ids BUF_TOP/BUF_LEFT/BUF_DOWN;
  - ctrl encodings CTRL_IDLE=0, CTRL_STEADY=1, CTRL_DRAIN=3;
  - the state enum typedef.
- One sub-module, seq_addr_window: holds one start/end register pair with load enable and wrap-add. It is instantiated three times (top/left/down).

Test Plan:
- Reset, then LD buf=1 loc=0x3E2 -> left start=2, end=8 next cycle; others 0; o_err=0.
- LD buf=0 loc=30 -> top start=30, end=4 (wrap).
- GEMM accepted at cycle t -> o_ctrl_state=1 for cycles t+1..t+10, 0 at t+11; o_inst_ready=0 throughout the phase.
- DRAINSYS, then ST after LD buf=2 loc=5 -> DRAIN for 6 cycles; then o_down_rd_en high 4 cycles with addr 5,6,7,8.
- Opcode 4'b1111 -> o_err single pulse, state stays 0. LD buf=3 -> o_err pulse, no window changes.
- rst asserted at 3rd STEADY cycle -> next cycle o_ctrl_state=0, o_busy=0, windows 0.
- With GEMM_AUTO_DRAIN_EN: GEMM -> 10 cycles STEADY then 6 cycles DRAIN contiguous.

Source files
------------

// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gemm_pkg
// Description : Shared opcodes, buffer ids, array ctrl encodings and the
//               sequencer state type for gemm_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package gemm_pkg;

    localparam logic [3:0] OPC_LD       = 4'b0010;
    localparam logic [3:0] OPC_ST       = 4'b0011;
    localparam logic [3:0] OPC_GEMM     = 4'b0100;
    localparam logic [3:0] OPC_DRAINSYS = 4'b0101;

    localparam logic [1:0] BUF_TOP  = 2'd0;
    localparam logic [1:0] BUF_LEFT = 2'd1;
    localparam logic [1:0] BUF_DOWN = 2'd2;
    localparam logic [1:0] BUF_RSVD = 2'd3;

    localparam logic [3:0] CTRL_IDLE   = 4'd0;
    localparam logic [3:0] CTRL_STEADY = 4'd1;
    localparam logic [3:0] CTRL_DRAIN  = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEADY = 2'd1,
        S_DRAIN  = 2'd2,
        S_STORE  = 2'd3
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_addr_window.sv
`default_nettype none
// ============================================================================
// Module      : seq_addr_window
// Description : One SRAM read window: start/end register pair loaded from a
//               base location, end = start + SPAN with modulo wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_addr_window #(
    parameter int ADDR_W = 5,
    parameter int SPAN   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_loc,
    output logic [ADDR_W-1:0] o_start,
    output logic [ADDR_W-1:0] o_end
);

    localparam logic [ADDR_W-1:0] c_span = ADDR_W'(SPAN);

    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W-1:0] r_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start <= '0;
            r_end   <= '0;
        end else if (i_load) begin
            r_start <= i_loc;
            r_end   <= i_loc + c_span;
        end
    end

    assign o_start = r_start;
    assign o_end   = r_end;

endmodule
`default_nettype wire

// File: rtl/gemm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gemm_sequencer
// Description : Instruction-driven LD/ST/GEMM/DRAINSYS controller for the
//               systolic array with counted STEADY/DRAIN/STORE phases.
//               Option macro GEMM_AUTO_DRAIN_EN chains DRAIN after STEADY.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_sequencer
    import gemm_pkg::*;
#(
    parameter int NUM_ROW              = 4,
    parameter int NUM_COL              = 4,
    parameter int LOG2_SRAM_BANK_DEPTH = 5,
    parameter int CTRL_WIDTH           = 4,
    parameter int OPCODE_WIDTH         = 4,
    parameter int BUF_ID_WIDTH         = 2,
    parameter int MEM_LOC_WIDTH        = 10,
    parameter int STEADY_CYCLES        = 10,
    parameter int DRAIN_CYCLES         = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_inst_valid,
    output logic                            o_inst_ready,
    input  logic [OPCODE_WIDTH-1:0]         i_opcode,
    input  logic [BUF_ID_WIDTH-1:0]         i_buf_id,
    input  logic [MEM_LOC_WIDTH-1:0]        i_mem_loc,
    output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_rd_end_addr,
    output logic                            o_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_rd_addr,
    output logic                            o_busy,
    output logic                            o_err
);

    localparam int c_addr_w    = LOG2_SRAM_BANK_DEPTH;
    localparam int c_max_phase = max3(STEADY_CYCLES, DRAIN_CYCLES, NUM_ROW);
    localparam int c_cnt_w     = $clog2(c_max_phase) + 1;

    localparam logic [c_cnt_w-1:0] c_steady_ld = c_cnt_w'(STEADY_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_drain_ld  = c_cnt_w'(DRAIN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_store_ld  = c_cnt_w'(NUM_ROW - 1);

    localparam logic [OPCODE_WIDTH-1:0] c_opc_ld    = OPCODE_WIDTH'(OPC_LD);
    localparam logic [OPCODE_WIDTH-1:0] c_opc_st    = OPCODE_WIDTH'(OPC_ST);
    localparam logic [OPCODE_WIDTH-1:0] c_opc_gemm  = OPCODE_WIDTH'(OPC_GEMM);
    localparam logic [OPCODE_WIDTH-1:0] c_opc_drain = OPCODE_WIDTH'(OPC_DRAINSYS);

    localparam logic [BUF_ID_WIDTH-1:0] c_buf_top  = BUF_ID_WIDTH'(BUF_TOP);
    localparam logic [BUF_ID_WIDTH-1:0] c_buf_left = BUF_ID_WIDTH'(BUF_LEFT);
    localparam logic [BUF_ID_WIDTH-1:0] c_buf_down = BUF_ID_WIDTH'(BUF_DOWN);

    localparam logic [CTRL_WIDTH-1:0] c_ctrl_idle   = CTRL_WIDTH'(CTRL_IDLE);
    localparam logic [CTRL_WIDTH-1:0] c_ctrl_steady = CTRL_WIDTH'(CTRL_STEADY);
    localparam logic [CTRL_WIDTH-1:0] c_ctrl_drain  = CTRL_WIDTH'(CTRL_DRAIN);

    generate
        if (STEADY_CYCLES < 1 || DRAIN_CYCLES < 1 || NUM_ROW < 1) begin : g_bad_phase
            $error("gemm_sequencer: phase lengths must be non-zero");
        end
        if (MEM_LOC_WIDTH < LOG2_SRAM_BANK_DEPTH) begin : g_bad_loc
            $error("gemm_sequencer: MEM_LOC_WIDTH narrower than SRAM address");
        end
    endgenerate

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_store_k;
    logic               r_err;
    logic               w_err_nxt;
    logic               r_rdy_en;
    logic               w_accept;
    logic               w_is_ld;
    logic               w_is_st;
    logic               w_is_gemm;
    logic               w_is_drain;
    logic               w_ld_top;
    logic               w_ld_left;
    logic               w_ld_down;
    logic               w_bad_buf;
    logic               w_rd_en;
    logic               w_unused_loc;
    logic [CTRL_WIDTH-1:0] w_ctrl;
    logic [c_addr_w-1:0]   w_loc;

    // ready is held low for the first cycle after reset releases
    assign o_inst_ready = r_rdy_en && (r_state == S_IDLE);
    assign w_accept     = i_inst_valid && o_inst_ready;

    assign w_is_ld    = (i_opcode == c_opc_ld);
    assign w_is_st    = (i_opcode == c_opc_st);
    assign w_is_gemm  = (i_opcode == c_opc_gemm);
    assign w_is_drain = (i_opcode == c_opc_drain);

    assign w_loc        = i_mem_loc[c_addr_w-1:0];
    assign w_unused_loc = ^i_mem_loc;

    assign w_bad_buf = !((i_buf_id == c_buf_top) || (i_buf_id == c_buf_left) ||
                         (i_buf_id == c_buf_down));
    assign w_ld_top  = w_accept && w_is_ld && (i_buf_id == c_buf_top);
    assign w_ld_left = w_accept && w_is_ld && (i_buf_id == c_buf_left);
    assign w_ld_down = w_accept && w_is_ld && (i_buf_id == c_buf_down);

    seq_addr_window #(
        .ADDR_W (c_addr_w),
        .SPAN   (NUM_ROW + NUM_COL - 2)
    ) u_top_win (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ld_top),
        .i_loc   (w_loc),
        .o_start (o_top_rd_start_addr),
        .o_end   (o_top_rd_end_addr)
    );

    seq_addr_window #(
        .ADDR_W (c_addr_w),
        .SPAN   (NUM_ROW + NUM_COL - 2)
    ) u_left_win (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ld_left),
        .i_loc   (w_loc),
        .o_start (o_left_rd_start_addr),
        .o_end   (o_left_rd_end_addr)
    );

    seq_addr_window #(
        .ADDR_W (c_addr_w),
        .SPAN   (NUM_ROW + NUM_COL - 2)
    ) u_down_win (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ld_down),
        .i_loc   (w_loc),
        .o_start (o_down_rd_start_addr),
        .o_end   (o_down_rd_end_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_ctrl      = c_ctrl_idle;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_gemm) begin
                        w_state_nxt = S_STEADY;
                        w_cnt_nxt   = c_steady_ld;
                    end else if (w_is_drain) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = c_drain_ld;
                    end else if (w_is_st) begin
                        w_state_nxt = S_STORE;
                        w_cnt_nxt   = c_store_ld;
                    end else if (w_is_ld) begin
                        w_err_nxt = w_bad_buf;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_STEADY: begin
                w_ctrl = c_ctrl_steady;
                if (r_cnt == '0) begin
`ifdef GEMM_AUTO_DRAIN_EN
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = c_drain_ld;
`else
                    w_state_nxt = S_IDLE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DRAIN: begin
                w_ctrl = c_ctrl_drain;
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_STORE: begin
                w_rd_en = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // the counter runs down, so the store offset is its distance from the load value
    assign w_store_k      = c_store_ld - r_cnt;
    assign o_down_rd_en   = w_rd_en;
    assign o_down_rd_addr = w_rd_en ? (o_down_rd_start_addr + c_addr_w'(w_store_k)) : '0;
    assign o_ctrl_state   = w_ctrl;
    assign o_busy         = (r_state != S_IDLE);
    assign o_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gemm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gemm_sequencer
// Description : Scoreboard bench for gemm_sequencer (honours GEMM_AUTO_DRAIN_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm_sequencer;

    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_GEMM  = 4'b0100;
    localparam logic [3:0] OP_DRAIN = 4'b0101;
    localparam logic [3:0] OP_BAD   = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inst_valid = 1'b0;
    logic       inst_ready;
    logic [3:0] opcode = '0;
    logic [1:0] buf_id = '0;
    logic [9:0] mem_loc = '0;
    logic [3:0] ctrl_state;
    logic [4:0] top_s, top_e, left_s, left_e, down_s, down_e;
    logic       down_rd_en;
    logic [4:0] down_rd_addr;
    logic       busy;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] ctrl;
        logic       rd_en;
        logic [4:0] addr;
        logic       ready;
        logic       busy;
        logic       err;
    } exp_t;

    exp_t        exp_q[$];
    logic [29:0] win_q[$];

    gemm_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_inst_valid         (inst_valid),
        .o_inst_ready         (inst_ready),
        .i_opcode             (opcode),
        .i_buf_id             (buf_id),
        .i_mem_loc            (mem_loc),
        .o_ctrl_state         (ctrl_state),
        .o_top_rd_start_addr  (top_s),
        .o_top_rd_end_addr    (top_e),
        .o_left_rd_start_addr (left_s),
        .o_left_rd_end_addr   (left_e),
        .o_down_rd_start_addr (down_s),
        .o_down_rd_end_addr   (down_e),
        .o_down_rd_en         (down_rd_en),
        .o_down_rd_addr       (down_rd_addr),
        .o_busy               (busy),
        .o_err                (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void push(input logic [3:0] c, input logic r, input logic [4:0] a,
                                 input logic rdy, input logic b, input logic e);
        exp_t x;
        x.ctrl = c; x.rd_en = r; x.addr = a; x.ready = rdy; x.busy = b; x.err = e;
        exp_q.push_back(x);
    endfunction

    // Holds valid until a cycle with ready high; returns 1ns into the cycle after acceptance.
    task automatic issue(input logic [3:0] op, input logic [1:0] b, input logic [9:0] loc);
        logic rdy;
        bit   done;
        @(posedge clk); #1;
        inst_valid = 1'b1; opcode = op; buf_id = b; mem_loc = loc;
        done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk); rdy = inst_ready;
            @(posedge clk); #1;
            if (rdy) done = 1;
        end
        inst_valid = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL issue_timeout: op=%b never accepted, ready=%0b required 1", op, inst_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({ctrl_state, inst_ready, busy, err, down_rd_en} !== 8'b0 ||
            {top_s, top_e, left_s, left_e, down_s, down_e} !== 30'b0) begin
            n_fail++;
            $display("FAIL reset_state: ctrl=%0d ready=%0b busy=%0b err=%0b rd_en=%0b win=%h, required all 0",
                     ctrl_state, inst_ready, busy, err, down_rd_en,
                     {top_s, top_e, left_s, left_e, down_s, down_e});
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        n_tests++;
        if (inst_ready !== 1'b1 || busy !== 1'b0 || ctrl_state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%0b busy=%0b ctrl=%0d, required 1/0/0",
                     inst_ready, busy, ctrl_state);
        end
    endtask

    task automatic test_ld();
        logic [1:0]  bufs[3];
        logic [9:0]  locs[3];
        logic [29:0] wins[3];
        logic [29:0] w;
        bufs = '{2'd1, 2'd0, 2'd2};
        locs = '{10'h3E2, 10'd30, 10'd5};
        wins = '{{5'd0, 5'd0, 5'd2, 5'd8, 5'd0, 5'd0},
                 {5'd30, 5'd4, 5'd2, 5'd8, 5'd0, 5'd0},
                 {5'd30, 5'd4, 5'd2, 5'd8, 5'd5, 5'd11}};
        for (int i = 0; i < 3; i++) begin
            win_q.push_back(wins[i]);
            issue(OP_LD, bufs[i], locs[i]);
            @(negedge clk);
            w = win_q.pop_front();
            n_tests++;
            if ({top_s, top_e, left_s, left_e, down_s, down_e} !== w || err !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL ld_%0d: win=%h err=%0b busy=%0b, required win=%h err=0 busy=0",
                         i, {top_s, top_e, left_s, left_e, down_s, down_e}, err, busy, w);
            end
        end
    endtask

    task automatic test_gemm();
        exp_t e;
        int   cyc;
        for (int i = 0; i < 10; i++) push(4'd1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
`ifdef GEMM_AUTO_DRAIN_EN
        for (int i = 0; i < 6; i++) push(4'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
`endif
        push(4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        issue(OP_GEMM, 2'd3, 10'h3FF);
        cyc = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            n_tests++;
            if ({ctrl_state, down_rd_en, inst_ready, busy, err} !== {e.ctrl, e.rd_en, e.ready, e.busy, e.err}) begin
                n_fail++;
                $display("FAIL gemm t+%0d: ctrl=%0d rd_en=%0b ready=%0b busy=%0b err=%0b, required ctrl=%0d rd_en=%0b ready=%0b busy=%0b err=%0b",
                         cyc, ctrl_state, down_rd_en, inst_ready, busy, err, e.ctrl, e.rd_en, e.ready, e.busy, e.err);
            end
            cyc++;
        end
    endtask

    task automatic test_drain_store();
        exp_t e;
        int   cyc;
        logic [4:0] bases[2];
        bases = '{5'd5, 5'd30};
        for (int p = 0; p < 3; p++) begin
            if (p == 0) begin
                for (int i = 0; i < 6; i++) push(4'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
                push(4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
                issue(OP_DRAIN, 2'd0, 10'd0);
            end else begin
                if (p == 2) begin
                    win_q.push_back({5'd30, 5'd4, 5'd2, 5'd8, 5'd30, 5'd4});
                    issue(OP_LD, 2'd2, 10'd30);
                    @(negedge clk);
                    n_tests++;
                    if ({top_s, top_e, left_s, left_e, down_s, down_e} !== win_q[0]) begin
                        n_fail++;
                        $display("FAIL ld_down_wrap: win=%h, required %h",
                                 {top_s, top_e, left_s, left_e, down_s, down_e}, win_q[0]);
                    end
                    void'(win_q.pop_front());
                end
                for (int k = 0; k < 4; k++) push(4'd0, 1'b1, bases[p-1] + 5'(k), 1'b0, 1'b1, 1'b0);
                push(4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
                issue(OP_ST, 2'd0, 10'd0);
            end
            cyc = 1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                n_tests++;
                if ({ctrl_state, down_rd_en, inst_ready, busy, err} !== {e.ctrl, e.rd_en, e.ready, e.busy, e.err} ||
                    (e.rd_en && down_rd_addr !== e.addr)) begin
                    n_fail++;
                    $display("FAIL drain_store p%0d t+%0d: ctrl=%0d rd_en=%0b addr=%0d ready=%0b busy=%0b, required ctrl=%0d rd_en=%0b addr=%0d ready=%0b busy=%0b",
                             p, cyc, ctrl_state, down_rd_en, down_rd_addr, inst_ready, busy,
                             e.ctrl, e.rd_en, e.addr, e.ready, e.busy);
                end
                cyc++;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        for (int i = 0; i < 10; i++) push(4'd1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
`ifdef GEMM_AUTO_DRAIN_EN
        for (int i = 0; i < 6; i++) push(4'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
`endif
        push(4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) push(4'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        push(4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        issue(OP_GEMM, 2'd0, 10'd0);
        fork
            issue(OP_DRAIN, 2'd0, 10'd0);
            begin
                cyc = 1;
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    n_tests++;
                    if ({ctrl_state, down_rd_en, inst_ready, busy, err} !== {e.ctrl, e.rd_en, e.ready, e.busy, e.err}) begin
                        n_fail++;
                        $display("FAIL back_to_back t+%0d: ctrl=%0d ready=%0b busy=%0b, required ctrl=%0d ready=%0b busy=%0b",
                                 cyc, ctrl_state, inst_ready, busy, e.ctrl, e.ready, e.busy);
                    end
                    cyc++;
                end
            end
        join
    endtask

    task automatic test_errors();
        exp_t e;
        logic [3:0] ops[2];
        logic [1:0] bufs[2];
        ops  = '{OP_BAD, OP_LD};
        bufs = '{2'd1, 2'd3};
        for (int p = 0; p < 2; p++) begin
            push(4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
            push(4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
            issue(ops[p], bufs[p], 10'd17);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                n_tests++;
                if ({ctrl_state, down_rd_en, inst_ready, busy, err} !== {e.ctrl, e.rd_en, e.ready, e.busy, e.err}) begin
                    n_fail++;
                    $display("FAIL err_%0d: ctrl=%0d ready=%0b busy=%0b err=%0b, required ctrl=%0d ready=%0b busy=%0b err=%0b",
                             p, ctrl_state, inst_ready, busy, err, e.ctrl, e.ready, e.busy, e.err);
                end
            end
        end
        n_tests++;
        if ({top_s, top_e, left_s, left_e, down_s, down_e} !== {5'd30, 5'd4, 5'd2, 5'd8, 5'd30, 5'd4}) begin
            n_fail++;
            $display("FAIL err_windows: win=%h, required %h", {top_s, top_e, left_s, left_e, down_s, down_e},
                     {5'd30, 5'd4, 5'd2, 5'd8, 5'd30, 5'd4});
        end
    endtask

    task automatic test_reset_mid();
        issue(OP_GEMM, 2'd0, 10'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (ctrl_state !== 4'd1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: ctrl=%0d, required 1", ctrl_state);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (ctrl_state !== 4'd0 || busy !== 1'b0 || inst_ready !== 1'b0 ||
            {top_s, top_e, left_s, left_e, down_s, down_e} !== 30'b0) begin
            n_fail++;
            $display("FAIL rst_mid: ctrl=%0d busy=%0b ready=%0b win=%h, required 0/0/0/0",
                     ctrl_state, busy, inst_ready, {top_s, top_e, left_s, left_e, down_s, down_e});
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        n_tests++;
        if (inst_ready !== 1'b1 || ctrl_state !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mid_release: ready=%0b ctrl=%0d, required 1/0", inst_ready, ctrl_state);
        end
    endtask

    initial begin
        test_reset();
        test_ld();
        test_gemm();
        test_drain_store();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
